rom_ddr3_bridge: RTL and testbench

Single-clock responder that serves the cartridge ROM toggle handshakes on the DDR3 side. It accepts 16-bit ROM-load writes and 16-bit CPU ROM reads, each as a req/ack toggle pair. It converts them into single-beat 64-bit Avalon transactions on the DDRAM port. A one-line, 64-bit read cache returns sequential ROM fetches without a DDR3 round trip.

---
 rtl/rom_ddr3_bridge_if.sv | 23 ++
 rtl/rom_ddr3_bridge.sv | 170 +++++++++++++++++
 tb/tb_rom_ddr3_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_ddr3_bridge_if.sv
// Single-beat Avalon-MM port toward the DDR3 controller.
// master = bridge side, slave = memory/controller side.
interface rom_ddr3_bridge_if;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    modport master (
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport slave (
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );
endinterface

// File: rtl/rom_ddr3_bridge.sv
// Cartridge ROM toggle-handshake responder on DDR3: 16-bit writes/reads become 64-bit
// single-beat Avalon transactions; a one-line read cache serves sequential fetches.
module rom_ddr3_bridge #(
    parameter logic [3:0] BASE_HI = 4'h3
) (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    input  logic [24:0] wraddr,
    input  logic [15:0] din,
    input  logic        we_req,
    output logic        we_ack,
    input  logic [22:1] rdaddr,
    output logic [15:0] dout,
    input  logic        rd_req,
    output logic        rd_ack,
    rom_ddr3_bridge_if.master ddram
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDWAIT,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic        we_ack_q, we_ack_d;
    logic        rd_ack_q, rd_ack_d;
    logic [15:0] dout_q, dout_d;
    logic [28:0] addr_q, addr_d;
    logic [63:0] din_q, din_d;
    logic [7:0]  be_q, be_d;
    logic        we_q, we_d;
    logic        rd_q, rd_d;
    logic [63:0] line_q, line_d;
    logic [19:0] tag_q, tag_d;
    logic        valid_q, valid_d;

    logic        busy;
    logic        ready;
    logic        wr_pend;
    logic        rd_pend;
    logic        hit;
    logic [28:0] wr_line;
    logic [28:0] rd_line;
    logic        unused_bits;

    assign busy    = ddram.DDRAM_BUSY;
    assign ready   = ddram.DDRAM_DOUT_READY;
    assign wr_pend = we_req ^ we_ack_q;
    assign rd_pend = rd_req ^ rd_ack_q;
    assign hit     = valid_q && (tag_q == rdaddr[22:3]);
    assign wr_line = {BASE_HI, 3'b000, wraddr[24:3]};
    assign rd_line = {BASE_HI, 3'b000, 2'b00, rdaddr[22:3]};
    // Byte lane 0 of a 16-bit word carries no address information.
    assign unused_bits = wraddr[0];

    always_comb begin
        state_d  = state_q;
        we_ack_d = we_ack_q;
        rd_ack_d = rd_ack_q;
        dout_d   = dout_q;
        addr_d   = addr_q;
        din_d    = din_q;
        be_d     = be_q;
        we_d     = we_q;
        rd_d     = rd_q;
        line_d   = line_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (wr_pend) begin
                    addr_d  = wr_line;
                    din_d   = {4{din}};
                    be_d    = 8'b0000_0011 << {wraddr[2:1], 1'b0};
                    we_d    = 1'b1;
                    state_d = S_WR;
                end else if (rd_pend && hit) begin
                    dout_d   = line_q[{rdaddr[2:1], 4'b0000} +: 16];
                    rd_ack_d = ~rd_ack_q;
                end else if (rd_pend) begin
                    addr_d  = rd_line;
                    rd_d    = 1'b1;
                    state_d = S_RD;
                end
            end
            S_WR: begin
                if (!busy) begin
                    we_d     = 1'b0;
                    we_ack_d = ~we_ack_q;
                    state_d  = S_IDLE;
                    // Writing into the cached line makes the cached copy stale.
                    if (addr_q[21:0] == {2'b00, tag_q}) begin
                        valid_d = 1'b0;
                    end
                end
            end
            S_RD: begin
                if (!busy) begin
                    rd_d    = 1'b0;
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                if (ready) begin
                    line_d   = ddram.DDRAM_DOUT;
                    tag_d    = rdaddr[22:3];
                    valid_d  = 1'b1;
                    dout_d   = ddram.DDRAM_DOUT[{rdaddr[2:1], 4'b0000} +: 16];
                    rd_ack_d = ~rd_ack_q;
                    state_d  = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            // A read already accepted by the controller still owes one data beat.
            if (state_q == S_RDWAIT || (state_q == S_RD && !busy)) begin
                state_q <= S_DRAIN;
            end else begin
                state_q <= S_IDLE;
            end
            we_ack_q <= we_req;
            rd_ack_q <= rd_req;
            dout_q   <= 16'h0000;
            addr_q   <= 29'h0;
            din_q    <= 64'h0;
            be_q     <= 8'h00;
            we_q     <= 1'b0;
            rd_q     <= 1'b0;
            line_q   <= 64'h0;
            tag_q    <= 20'h0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_ack_q <= we_ack_d;
            rd_ack_q <= rd_ack_d;
            dout_q   <= dout_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            be_q     <= be_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            line_q   <= line_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
        end
    end

    assign we_ack               = we_ack_q;
    assign rd_ack               = rd_ack_q;
    assign dout                 = dout_q;
    assign ddram.DDRAM_BURSTCNT = 8'd1;
    assign ddram.DDRAM_ADDR     = addr_q;
    assign ddram.DDRAM_DIN      = din_q;
    assign ddram.DDRAM_BE       = be_q;
    assign ddram.DDRAM_WE       = we_q;
    assign ddram.DDRAM_RD       = rd_q;

endmodule

// File: tb/tb_rom_ddr3_bridge.sv
// Bench for rom_ddr3_bridge: directed vector table and corner sequences, then random
// traffic against a word-array ROM model, a one-line cache model and a DDR responder.
module tb_rom_ddr3_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] wraddr;
    logic [15:0] din;
    logic        we_req;
    logic        we_ack;
    logic [22:1] rdaddr;
    logic [15:0] dout;
    logic        rd_req;
    logic        rd_ack;

    always #5 clk = ~clk;

    rom_ddr3_bridge_if ddr ();

    rom_ddr3_bridge #(.BASE_HI(4'h3)) dut (
        .DDRAM_CLK (clk),
        .reset     (reset),
        .wraddr    (wraddr),
        .din       (din),
        .we_req    (we_req),
        .we_ack    (we_ack),
        .rdaddr    (rdaddr),
        .dout      (dout),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .ddram     (ddr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- initial ROM content shared by both models ----------------
    function automatic logic [15:0] def_word(input logic [23:0] w);
        return (w[15:0] * 16'd40503) ^ 16'h5AC3;
    endfunction

    // ---------------- DDR3 responder (64-bit word memory) ----------------
    typedef struct {
        int          t;
        logic [63:0] d;
    } rsp_t;

    logic [63:0] ddr_mem [logic [28:0]];
    rsp_t        rq[$];
    int          cyc = 0;
    int          rd_cmds = 0;
    int          busy_hold = 0;
    bit          rnd_busy = 0;
    int          dly_min = 1;
    int          dly_max = 1;
    logic [28:0] last_rd_addr = '0;

    function automatic logic [63:0] ddr_get(input logic [28:0] a);
        logic [63:0] v;
        if (ddr_mem.exists(a)) return ddr_mem[a];
        for (int i = 0; i < 4; i++) v[16*i +: 16] = def_word({a[21:0], 2'(i)});
        return v;
    endfunction

    initial begin
        ddr.DDRAM_BUSY       = 1'b0;
        ddr.DDRAM_DOUT_READY = 1'b0;
        ddr.DDRAM_DOUT       = 64'h0;
        forever begin
            @(negedge clk);
            cyc++;
            ddr.DDRAM_DOUT_READY = 1'b0;
            if (rq.size() > 0 && rq[0].t <= cyc) begin
                ddr.DDRAM_DOUT       = rq[0].d;
                ddr.DDRAM_DOUT_READY = 1'b1;
                void'(rq.pop_front());
            end else begin
                ddr.DDRAM_DOUT = {$urandom, $urandom};
            end
            if (busy_hold > 0) begin
                ddr.DDRAM_BUSY = 1'b1;
                busy_hold--;
            end else begin
                ddr.DDRAM_BUSY = rnd_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            if (ddr.DDRAM_RD && ddr.DDRAM_WE) begin
                errors++;
                $display("FAIL rd_we_overlap: RD=%b WE=%b at cycle %0d", ddr.DDRAM_RD, ddr.DDRAM_WE, cyc);
            end
            if (!ddr.DDRAM_BUSY && ddr.DDRAM_RD) begin
                int t;
                rd_cmds++;
                last_rd_addr = ddr.DDRAM_ADDR;
                t = cyc + $urandom_range(dly_min, dly_max);
                if (rq.size() > 0 && t <= rq[$].t) t = rq[$].t + 1;
                rq.push_back('{t, ddr_get(ddr.DDRAM_ADDR)});
            end
            if (!ddr.DDRAM_BUSY && ddr.DDRAM_WE) begin
                logic [63:0] v;
                v = ddr_get(ddr.DDRAM_ADDR);
                for (int b = 0; b < 8; b++)
                    if (ddr.DDRAM_BE[b]) v[8*b +: 8] = ddr.DDRAM_DIN[8*b +: 8];
                ddr_mem[ddr.DDRAM_ADDR] = v;
            end
        end
    end

    // ---------------- reference model: 16-bit ROM words + one cached line ----------------
    logic [15:0] rom_ref [logic [23:0]];
    bit          c_valid = 0;
    logic [21:0] c_line = '0;

    function automatic logic [15:0] ref_get(input logic [23:0] w);
        if (rom_ref.exists(w)) return rom_ref[w];
        return def_word(w);
    endfunction

    task automatic model_write(input logic [24:0] wa, input logic [15:0] wd);
        rom_ref[wa[24:1]] = wd;
        if (c_valid && 22'(wa >> 3) == c_line) c_valid = 0;
    endtask

    task automatic model_read(input logic [22:1] ra, output bit miss, output logic [15:0] expd);
        logic [21:0] ln;
        ln   = 22'({ra, 1'b0} >> 3);
        miss = !(c_valid && c_line == ln);
        expd = ref_get({2'b00, ra});
        c_valid = 1;
        c_line  = ln;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a write and/or a read, wait for both acks, check data and DDR read usage.
    task automatic do_op(input bit w, input logic [24:0] wa, input logic [15:0] wd,
                         input bit r, input logic [22:1] ra, input string tag, output int edges);
        int          rc0;
        bit          miss;
        bit          done;
        logic [15:0] expd;
        rc0  = rd_cmds;
        miss = 0;
        expd = '0;
        done = 0;
        if (w) begin wraddr = wa; din = wd; we_req = ~we_req; model_write(wa, wd); end
        if (r) begin rdaddr = ra; rd_req = ~rd_req; model_read(ra, miss, expd); end
        edges = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            edges++;
            if (we_ack == we_req && rd_ack == rd_req) done = 1;
        end
        chk({tag, " done"}, 64'(done), 64'd1);
        if (r) begin
            chk({tag, " dout"}, 64'(dout), 64'(expd));
            chk({tag, " rd_cmds"}, 64'(rd_cmds - rc0), 64'(miss));
        end
    endtask

    typedef struct {
        logic [24:0] wa;
        logic [15:0] d;
        logic [28:0] ea;
        logic [7:0]  ebe;
        logic [63:0] ed;
    } wvec_t;

    wvec_t wt[5];

    initial begin
        int          e;
        int          k;
        int          rc0;
        bit          miss;
        logic [15:0] expd;
        logic [28:0] a0;
        logic [63:0] d0;
        logic [7:0]  b0;

        wt[0] = '{25'h0000006, 16'hBEEF, 29'h06000000, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF};
        wt[1] = '{25'h0000000, 16'h0102, 29'h06000000, 8'h03, 64'h0102_0102_0102_0102};
        wt[2] = '{25'h0000003, 16'hA55A, 29'h06000000, 8'h0C, 64'hA55A_A55A_A55A_A55A};
        wt[3] = '{25'h1FFFFFE, 16'hCAFE, 29'h063FFFFF, 8'hC0, 64'hCAFE_CAFE_CAFE_CAFE};
        wt[4] = '{25'h000002C, 16'h7777, 29'h06000005, 8'h30, 64'h7777_7777_7777_7777};

        reset  = 1'b1;
        we_req = 1'b0;
        rd_req = 1'b0;
        wraddr = '0;
        din    = '0;
        rdaddr = '0;
        repeat (3) tick();
        reset = 1'b0;

        chk("reset RD", 64'(ddr.DDRAM_RD), 64'd0);
        chk("reset WE", 64'(ddr.DDRAM_WE), 64'd0);
        chk("reset ADDR", 64'(ddr.DDRAM_ADDR), 64'd0);
        chk("reset DIN", ddr.DDRAM_DIN, 64'd0);
        chk("reset BE", 64'(ddr.DDRAM_BE), 64'd0);
        chk("reset dout", 64'(dout), 64'd0);
        chk("reset BURSTCNT", 64'(ddr.DDRAM_BURSTCNT), 64'd1);
        chk("reset acks", 64'({we_ack, rd_ack}), 64'd0);

        // Write vector table: one WE cycle with BUSY=0, then ack.
        for (int i = 0; i < 5; i++) begin
            wraddr = wt[i].wa;
            din    = wt[i].d;
            we_req = ~we_req;
            model_write(wt[i].wa, wt[i].d);
            tick();
            chk($sformatf("wr%0d WE", i), 64'(ddr.DDRAM_WE), 64'd1);
            chk($sformatf("wr%0d RD", i), 64'(ddr.DDRAM_RD), 64'd0);
            chk($sformatf("wr%0d ADDR", i), 64'(ddr.DDRAM_ADDR), 64'(wt[i].ea));
            chk($sformatf("wr%0d BE", i), 64'(ddr.DDRAM_BE), 64'(wt[i].ebe));
            chk($sformatf("wr%0d DIN", i), ddr.DDRAM_DIN, wt[i].ed);
            tick();
            chk($sformatf("wr%0d ack", i), 64'(we_ack), 64'(we_req));
            chk($sformatf("wr%0d WE low", i), 64'(ddr.DDRAM_WE), 64'd0);
        end

        // Miss then hits within line 1, minimum latency.
        ddr_mem[29'h06000001] = 64'h4444_3333_2222_1111;
        rom_ref[24'd4] = 16'h1111;
        rom_ref[24'd5] = 16'h2222;
        rom_ref[24'd6] = 16'h3333;
        rom_ref[24'd7] = 16'h4444;
        do_op(0, '0, '0, 1, 22'h000006, "miss6", e);
        chk("miss6 latency", 64'(e), 64'd3);
        chk("miss6 addr", 64'(last_rd_addr), 64'h06000001);
        do_op(0, '0, '0, 1, 22'h000007, "hit7", e);
        chk("hit7 latency", 64'(e), 64'd1);
        do_op(0, '0, '0, 1, 22'h000004, "hit4", e);
        chk("hit4 latency", 64'(e), 64'd1);

        // Write held off by BUSY for 5 cycles.
        busy_hold = 6;
        wraddr = 25'h0000010;
        din    = 16'h5555;
        we_req = ~we_req;
        model_write(25'h0000010, 16'h5555);
        tick();
        chk("busy WE", 64'(ddr.DDRAM_WE), 64'd1);
        a0 = ddr.DDRAM_ADDR;
        d0 = ddr.DDRAM_DIN;
        b0 = ddr.DDRAM_BE;
        k  = 0;
        while (we_ack != we_req && k < 20) begin
            tick();
            k++;
            if (we_ack != we_req) begin
                chk("busy WE held", 64'(ddr.DDRAM_WE), 64'd1);
                chk("busy ADDR held", 64'(ddr.DDRAM_ADDR), 64'(a0));
                chk("busy DIN held", ddr.DDRAM_DIN, d0);
                chk("busy BE held", 64'(ddr.DDRAM_BE), 64'(b0));
            end
        end
        chk("busy ack edge", 64'(k), 64'd6);
        chk("busy ADDR value", 64'(a0), 64'h06000002);

        // Write and read requested together: write first, read right after its ack.
        wraddr = 25'h0000040;
        din    = 16'h9A9A;
        we_req = ~we_req;
        rdaddr = 22'h000010;
        rd_req = ~rd_req;
        model_write(25'h0000040, 16'h9A9A);
        model_read(22'h000010, miss, expd);
        rc0 = rd_cmds;
        tick();
        chk("both WE first", 64'({ddr.DDRAM_WE, ddr.DDRAM_RD}), 64'b10);
        tick();
        chk("both we_ack", 64'(we_ack), 64'(we_req));
        chk("both rd pending", 64'(rd_ack != rd_req), 64'd1);
        chk("both idle gap", 64'({ddr.DDRAM_WE, ddr.DDRAM_RD}), 64'b00);
        tick();
        chk("both RD next", 64'(ddr.DDRAM_RD), 64'd1);
        k = 0;
        while (rd_ack != rd_req && k < 50) begin tick(); k++; end
        chk("both rd done", 64'(rd_ack), 64'(rd_req));
        chk("both dout", 64'(dout), 64'(expd));
        repeat (3) tick();
        chk("both acks once", 64'({we_ack, rd_ack}), 64'({we_req, rd_req}));
        chk("both one RD", 64'(rd_cmds - rc0), 64'd1);

        // Write into the cached line invalidates it.
        do_op(0, '0, '0, 1, 22'h000000, "inv fill", e);
        do_op(0, '0, '0, 1, 22'h000001, "inv hit", e);
        do_op(1, 25'h0000000, 16'h1234, 0, '0, "inv write", e);
        do_op(0, '0, '0, 1, 22'h000000, "inv reread", e);
        chk("inv reread value", 64'(dout), 64'h1234);

        // Reset while waiting for read data; the late beat must be discarded.
        dly_min = 10;
        dly_max = 10;
        rc0 = rd_cmds;
        rdaddr = 22'h000020;
        rd_req = ~rd_req;
        k = 0;
        while (rd_cmds == rc0 && k < 50) begin tick(); k++; end
        chk("stale RD issued", 64'(rd_cmds - rc0), 64'd1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c_valid = 0;
        chk("rst acks", 64'({we_ack, rd_ack}), 64'({we_req, rd_req}));
        chk("rst dout", 64'(dout), 64'd0);
        chk("rst RD", 64'(ddr.DDRAM_RD), 64'd0);
        dly_min = 1;
        dly_max = 1;
        do_op(0, '0, '0, 1, 22'h000030, "post-reset read", e);

        // Random traffic with random BUSY and read latency.
        rnd_busy = 1;
        dly_min  = 1;
        dly_max  = 4;
        for (int n = 0; n < 250; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            do_op(kind < 3 || kind >= 8, 25'($urandom_range(0, 63)), 16'($urandom),
                  kind >= 3, 22'($urandom_range(0, 31)), $sformatf("rnd%0d", n), e);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
